// File: rtl/fft_out_streamer.sv
// +--------------------------------------------------------------------------+
// | fft_out_streamer: ping-pong capture of FFT frames, natural-order replay   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module fft_out_streamer #(
    parameter int PNT = 16,
    parameter int N   = $clog2(PNT),
    parameter int DW  = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en,
    input  logic [N-1:0]  wr_addr,
    input  logic [DW-1:0] wr_re,
    input  logic [DW-1:0] wr_im,
    input  logic          frame_done,
    output logic          in_rdy,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic [N-1:0]  out_idx,
    output logic          out_last,
    output logic          ovf
);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_FILL = 2'd1,
        R_STRM = 2'd2
    } rd_state_t;

    rd_state_t state;
    rd_state_t state_nx;

    logic [2*DW-1:0] mem [0:2*PNT-1];

    logic         wb;
    logic         rb;
    logic [1:0]   full;
    logic [1:0]   full_nx;
    logic         wr_ok;
    logic         commit;
    logic         frame_end;
    logic         rd_en;
    logic [N-1:0] rd_addr;

    assign in_rdy  = !full[wb];
    assign wr_ok   = wr_en && in_rdy;
    assign commit  = frame_done && in_rdy;
    assign out_vld = (state == R_STRM);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= R_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The output register doubles as the memory read register: it is only
    // reloaded on a handshake, so a stall simply freezes it.
    always_comb begin
        state_nx  = state;
        rd_en     = 1'b0;
        rd_addr   = out_idx + 1'b1;
        frame_end = 1'b0;
        case (state)
            R_IDLE: begin
                if (full[rb]) begin
                    state_nx = R_FILL;
                end
            end
            R_FILL: begin
                rd_en    = 1'b1;
                rd_addr  = '0;
                state_nx = R_STRM;
            end
            R_STRM: begin
                if (out_rdy) begin
                    if (out_last) begin
                        frame_end = 1'b1;
                        state_nx  = R_IDLE;
                    end else begin
                        rd_en = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = R_IDLE;
            end
        endcase
    end

    // Commit and release can never target the same bank in one cycle.
    always_comb begin
        full_nx = full;
        if (frame_end) begin
            full_nx[rb] = 1'b0;
        end
        if (commit) begin
            full_nx[wb] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full <= 2'b00;
            wb   <= 1'b0;
            rb   <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            full <= full_nx;
            if (commit) begin
                wb <= !wb;
            end
            if (frame_end) begin
                rb <= !rb;
            end
            if ((wr_en || frame_done) && !in_rdy) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[{wb, wr_addr}] <= {wr_re, wr_im};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_re   <= '0;
            out_im   <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
        end else if (rd_en) begin
            {out_re, out_im} <= mem[{rb, rd_addr}];
            out_idx          <= rd_addr;
            out_last         <= (rd_addr == N'(PNT - 1));
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fft_out_streamer.sv
// +--------------------------------------------------------------------------+
// | tb_fft_out_streamer: directed self-checking bench for fft_out_streamer    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fft_out_streamer;

    localparam int PNT = 16;
    localparam int N   = 4;
    localparam int DW  = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_en;
    logic [N-1:0]  wr_addr;
    logic [DW-1:0] wr_re;
    logic [DW-1:0] wr_im;
    logic          frame_done;
    logic          in_rdy;
    logic          out_vld;
    logic          out_rdy;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic [N-1:0]  out_idx;
    logic          out_last;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    fft_out_streamer #(.PNT(PNT), .N(N), .DW(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_re      (wr_re),
        .wr_im      (wr_im),
        .frame_done (frame_done),
        .in_rdy     (in_rdy),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          fd;
        logic          rdy;
        logic          vld;
        logic [N-1:0]  idx;
        logic          last;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } vec_t;

    vec_t tab [21];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] ref_re(input int fid, input int idx);
        return DW'((fid << 8) | idx);
    endfunction

    function automatic logic [DW-1:0] ref_im(input int fid, input int idx);
        return DW'(-((fid << 8) | idx));
    endfunction

    function automatic int bitrev(input int i);
        logic [N-1:0] v;
        logic [N-1:0] r;
        v = N'(i);
        for (int b = 0; b < N; b++) r[b] = v[N-1-b];
        return int'(r);
    endfunction

    task automatic write_frame(input int fid, input bit rev, input bit commit);
        for (int i = 0; i < PNT; i++) begin
            int a;
            a       = rev ? bitrev(i) : i;
            wr_en   = 1'b1;
            wr_addr = N'(a);
            wr_re   = ref_re(fid, a);
            wr_im   = ref_im(fid, a);
            tick();
        end
        wr_en = 1'b0;
        if (commit) begin
            frame_done = 1'b1;
            tick();
            frame_done = 1'b0;
        end
    endtask

    // mode 0: out_rdy held high; mode 1: deterministic stall pattern
    task automatic collect(input int fid, input int mode, input bit chk_ir);
        int            beats   = 0;
        int            cyc     = 0;
        bit            stalled = 0;
        logic [37:0]   held    = '0;
        logic [15:0]   pat     = 16'b1001_0110_1100_1011;
        while (beats < PNT && cyc < 300) begin
            if (stalled)
                chk("stall_hold", 64'({out_vld, out_last, out_idx, out_re, out_im}), 64'(held));
            out_rdy = (mode == 0) ? 1'b1 : pat[cyc[3:0]];
            if (out_vld && out_rdy) begin
                chk($sformatf("f%0d_idx", fid), 64'(out_idx), 64'(beats));
                chk($sformatf("f%0d_re_%0d", fid, beats), 64'(out_re), 64'(ref_re(fid, beats)));
                chk($sformatf("f%0d_im_%0d", fid, beats), 64'(out_im), 64'(ref_im(fid, beats)));
                chk($sformatf("f%0d_last_%0d", fid, beats), 64'(out_last), 64'(beats == PNT - 1));
                if (chk_ir && beats == PNT - 1)
                    chk("in_rdy_before_last", 64'(in_rdy), 64'(0));
                beats++;
            end
            stalled = out_vld && !out_rdy;
            held    = {out_vld, out_last, out_idx, out_re, out_im};
            tick();
            cyc++;
        end
        chk($sformatf("f%0d_beats", fid), 64'(beats), 64'(PNT));
        chk($sformatf("f%0d_vld_after_last", fid), 64'(out_vld), 64'(0));
        if (chk_ir)
            chk("in_rdy_after_last", 64'(in_rdy), 64'(1));
        out_rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_re = '0; wr_im = '0;
        frame_done = 1'b0; out_rdy = 1'b0;

        // Test 1 stream table: cycle 0 carries frame_done, beats on cycles 3..18
        for (int c = 0; c < 21; c++) begin
            tab[c].fd   = (c == 0);
            tab[c].rdy  = 1'b1;
            tab[c].vld  = (c >= 3 && c <= 18);
            tab[c].idx  = (c >= 3 && c <= 18) ? N'(c - 3) : '0;
            tab[c].last = (c == 18);
            tab[c].re   = (c >= 3 && c <= 18) ? ref_re(0, c - 3) : '0;
            tab[c].im   = (c >= 3 && c <= 18) ? ref_im(0, c - 3) : '0;
        end

        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld",    64'(out_vld),  64'(0));
        chk("rst_in_rdy", 64'(in_rdy),   64'(1));
        chk("rst_re",     64'(out_re),   64'(0));
        chk("rst_im",     64'(out_im),   64'(0));
        chk("rst_idx",    64'(out_idx),  64'(0));
        chk("rst_last",   64'(out_last), 64'(0));
        chk("rst_ovf",    64'(ovf),      64'(0));
        rstn = 1'b1;
        tick();

        // 1: natural-order frame, fixed latency
        write_frame(0, 1'b0, 1'b0);
        for (int c = 0; c < 21; c++) begin
            frame_done = tab[c].fd;
            out_rdy    = tab[c].rdy;
            chk($sformatf("t1_vld_c%0d", c), 64'(out_vld), 64'(tab[c].vld));
            chk($sformatf("t1_in_rdy_c%0d", c), 64'(in_rdy), 64'(1));
            if (tab[c].vld) begin
                chk($sformatf("t1_idx_c%0d", c),  64'(out_idx),  64'(tab[c].idx));
                chk($sformatf("t1_last_c%0d", c), 64'(out_last), 64'(tab[c].last));
                chk($sformatf("t1_re_c%0d", c),   64'(out_re),   64'(tab[c].re));
                chk($sformatf("t1_im_c%0d", c),   64'(out_im),   64'(tab[c].im));
            end
            tick();
        end
        frame_done = 1'b0;
        out_rdy    = 1'b0;
        chk("t1_ovf", 64'(ovf), 64'(0));

        // 2: bit-reversed write order
        write_frame(1, 1'b1, 1'b1);
        collect(1, 0, 1'b0);

        // 3: stalls
        write_frame(2, 1'b0, 1'b1);
        collect(2, 1, 1'b0);
        chk("t3_ovf", 64'(ovf), 64'(0));

        // 4: both banks full, overflow attempts
        out_rdy = 1'b0;
        write_frame(3, 1'b0, 1'b1);
        write_frame(4, 1'b0, 1'b1);
        chk("t4_in_rdy_full", 64'(in_rdy), 64'(0));
        chk("t4_ovf_before",  64'(ovf),    64'(0));
        chk("t4_vld_stalled", 64'({out_vld, out_idx}), 64'({1'b1, 4'd0}));
        wr_en = 1'b1; wr_addr = N'(5); wr_re = 16'hdead; wr_im = 16'hbeef;
        tick();
        wr_en = 1'b0;
        chk("t4_ovf_set", 64'(ovf), 64'(1));
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        chk("t4_in_rdy_still0", 64'(in_rdy), 64'(0));
        collect(3, 0, 1'b1);
        collect(4, 0, 1'b0);
        chk("t4_ovf_sticky", 64'(ovf), 64'(1));

        // 5: back-to-back frames
        begin
            int beats   = 0;
            int first_a = -1;
            int last_a  = -1;
            int first_b = -1;
            int last_b  = -1;
            write_frame(5, 1'b0, 1'b1);
            write_frame(6, 1'b0, 1'b1);
            for (int cyc = 0; cyc < 100 && beats < 2 * PNT; cyc++) begin
                out_rdy = 1'b1;
                if (out_vld) begin
                    chk("t5_idx", 64'(out_idx), 64'(beats % PNT));
                    chk("t5_re",  64'(out_re),  64'(ref_re(beats < PNT ? 5 : 6, beats % PNT)));
                    if (beats == 0)           first_a = cyc;
                    if (beats == PNT - 1)     last_a  = cyc;
                    if (beats == PNT)         first_b = cyc;
                    if (beats == 2 * PNT - 1) last_b  = cyc;
                    beats++;
                end
                tick();
            end
            out_rdy = 1'b0;
            chk("t5_beats", 64'(beats), 64'(2 * PNT));
            chk("t5_gap",   64'(first_b - last_a), 64'(3));
            chk("t5_span",  64'(last_b - first_a), 64'(2 * PNT + 1));
        end

        // 6: reset mid-stream
        write_frame(7, 1'b0, 1'b1);
        begin
            int k = 0;
            out_rdy = 1'b1;
            while (!(out_vld && out_idx == 4'd7) && k < 60) begin
                tick();
                k++;
            end
            chk("t6_reach_idx7", 64'({out_vld, out_idx}), 64'({1'b1, 4'd7}));
        end
        rstn = 1'b0;
        #1;
        chk("t6_rst_vld",    64'(out_vld), 64'(0));
        chk("t6_rst_in_rdy", 64'(in_rdy),  64'(1));
        chk("t6_rst_ovf",    64'(ovf),     64'(0));
        chk("t6_rst_idx",    64'(out_idx), 64'(0));
        out_rdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rstn = 1'b1;
        tick();
        write_frame(8, 1'b0, 1'b1);
        collect(8, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
